// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: 2-entry skid-buffered pipeline stage register
// with valid/ready handshake, registered in_ready and sync flush.
module pipe_stage_buf #(
    parameter int CTRL_W = 4,
    parameter int DATA_W = 64,
    parameter int RD_W   = 5,
    parameter int RW_BIT = 0,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [RD_W-1:0]   out_rd,
    output logic              fwd_we,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CTRL_W-1:0] hd_ctrl_q, hd_ctrl_d;
    logic [DATA_W-1:0] hd_data_q, hd_data_d;
    logic [RD_W-1:0]   hd_rd_q, hd_rd_d;
    logic [CTRL_W-1:0] sk_ctrl_q, sk_ctrl_d;
    logic [DATA_W-1:0] sk_data_q, sk_data_d;
    logic [RD_W-1:0]   sk_rd_q, sk_rd_d;
    logic              in_ready_q, in_ready_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic hd_valid;
    logic in_fire;
    logic out_fire;

    assign hd_valid  = (state_q != EMPTY);
    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = hd_valid & out_ready;

    assign in_ready  = in_ready_q;
    assign out_valid = hd_valid;
    assign out_ctrl  = hd_ctrl_q & {CTRL_W{hd_valid}};
    assign out_data  = hd_data_q;
    assign out_rd    = hd_rd_q;
    assign fwd_we    = hd_valid & hd_ctrl_q[RW_BIT];
    assign occupancy = state_q;
    assign stall_cnt = stall_cnt_q;

    // Next state, entry moves, flush clearing and stall counting
    always_comb begin
        state_d     = state_q;
        hd_ctrl_d   = hd_ctrl_q;
        hd_data_d   = hd_data_q;
        hd_rd_d     = hd_rd_q;
        sk_ctrl_d   = sk_ctrl_q;
        sk_data_d   = sk_data_q;
        sk_rd_d     = sk_rd_q;
        stall_cnt_d = stall_cnt_q;

        if (hd_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end

        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    hd_ctrl_d = in_ctrl;
                    hd_data_d = in_data;
                    hd_rd_d   = in_rd;
                    state_d   = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    hd_ctrl_d = in_ctrl;
                    hd_data_d = in_data;
                    hd_rd_d   = in_rd;
                end else if (in_fire) begin
                    sk_ctrl_d = in_ctrl;
                    sk_data_d = in_data;
                    sk_rd_d   = in_rd;
                    state_d   = FULL;
                end else if (out_fire) begin
                    state_d   = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    hd_ctrl_d = sk_ctrl_q;
                    hd_data_d = sk_data_q;
                    hd_rd_d   = sk_rd_q;
                    sk_ctrl_d = '0;
                    sk_rd_d   = '0;
                    state_d   = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        if (flush) begin
            state_d   = EMPTY;
            hd_ctrl_d = '0;
            hd_rd_d   = '0;
            sk_ctrl_d = '0;
            sk_rd_d   = '0;
        end

        in_ready_d = (state_d != FULL);
    end

    // State and storage registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            hd_ctrl_q   <= '0;
            hd_data_q   <= '0;
            hd_rd_q     <= '0;
            sk_ctrl_q   <= '0;
            sk_data_q   <= '0;
            sk_rd_q     <= '0;
            in_ready_q  <= 1'b1;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            hd_ctrl_q   <= hd_ctrl_d;
            hd_data_q   <= hd_data_d;
            hd_rd_q     <= hd_rd_d;
            sk_ctrl_q   <= sk_ctrl_d;
            sk_data_q   <= sk_data_d;
            sk_rd_q     <= sk_rd_d;
            in_ready_q  <= in_ready_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: scenario tasks plus a randomized run,
// checked against a queue-based FIFO model of the stage.
module tb_pipe_stage_buf;

    localparam int CW = 4;
    localparam int DW = 64;
    localparam int RW = 5;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
        logic [RW-1:0] r;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic [RW-1:0] in_rd;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [RW-1:0] out_rd;
    logic          fwd_we;
    logic [1:0]    occupancy;
    logic [15:0]   stall_cnt;

    logic          in_ready2;
    logic          out_valid2;
    logic [CW-1:0] out_ctrl2;
    logic [DW-1:0] out_data2;
    logic [RW-1:0] out_rd2;
    logic          fwd_we2;
    logic [1:0]    occupancy2;
    logic [1:0]    stall_cnt2;

    beat_t       mq[$];
    beat_t       exp_q[$];
    beat_t       got_q[$];
    int unsigned m_stall;
    int unsigned m_stall2;
    bit          m_in_fire;
    bit          dut_in_fire;
    int          total;
    int          bad;

    always #5 clk = ~clk;

    pipe_stage_buf #(
        .CTRL_W(CW), .DATA_W(DW), .RD_W(RW),
        .RW_BIT(0), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .in_rd(in_rd),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_data(out_data), .out_rd(out_rd),
        .fwd_we(fwd_we), .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    pipe_stage_buf #(
        .CTRL_W(CW), .DATA_W(DW), .RD_W(RW),
        .RW_BIT(0), .CNT_W(2)
    ) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_ctrl(in_ctrl), .in_data(in_data), .in_rd(in_rd),
        .flush(flush),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_ctrl(out_ctrl2), .out_data(out_data2), .out_rd(out_rd2),
        .fwd_we(fwd_we2), .occupancy(occupancy2), .stall_cnt(stall_cnt2)
    );

    // One clock: log DUT delivery, advance the model, step past the edge
    task automatic tick();
        beat_t b;
        bit    ifire;
        bit    ofire;
        b = {in_ctrl, in_data, in_rd};
        dut_in_fire = in_valid && in_ready;
        if (!rst && out_valid && out_ready)
            got_q.push_back({out_ctrl, out_data, out_rd});
        ifire = in_valid && (mq.size() < 2);
        ofire = (mq.size() > 0) && out_ready;
        if (rst) begin
            mq.delete();
            m_stall  = 0;
            m_stall2 = 0;
            ifire    = 1'b0;
        end else begin
            if ((mq.size() > 0) && !out_ready) begin
                if (m_stall < 65535) m_stall++;
                if (m_stall2 < 3) m_stall2++;
            end
            if (ofire) exp_q.push_back(mq[0]);
            if (flush) begin
                mq.delete();
                ifire = 1'b0;
            end else begin
                if (ofire) mq.delete(0);
                if (ifire) mq.push_back(b);
            end
        end
        m_in_fire = ifire;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rand();
        in_ctrl = CW'($urandom);
        in_data = {$urandom, $urandom};
        in_rd   = RW'($urandom);
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        in_rd     = '0;
        tick();
        tick();
        rst = 1'b0;
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        total++;
        if ({out_ctrl, out_data, out_rd} !== '0) begin
            bad++; $display("FAIL reset_out_fields: got %h/%h/%h want 0",
                            out_ctrl, out_data, out_rd);
        end
        total++;
        if ({fwd_we, occupancy, stall_cnt, stall_cnt2} !== '0) begin
            bad++; $display("FAIL reset_misc: fwd=%b occ=%0d st=%0d st2=%0d want 0",
                            fwd_we, occupancy, stall_cnt, stall_cnt2);
        end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_ctrl  = 4'b1001;
            in_data  = DW'(i);
            in_rd    = RW'(i);
            tick();
            total++;
            if (!out_valid || out_data !== DW'(i) || out_rd !== RW'(i)
                || out_ctrl !== 4'b1001) begin
                bad++; $display("FAIL stream_head%0d: got v=%b d=%0d rd=%0d c=%b want v=1 d=%0d",
                                i, out_valid, out_data, out_rd, out_ctrl, i);
            end
            total++;
            if (occupancy !== 2'd1 || fwd_we !== 1'b1) begin
                bad++; $display("FAIL stream_occ%0d: got occ=%0d fwd=%b want 1/1",
                                i, occupancy, fwd_we);
            end
        end
        in_valid = 1'b0;
        tick();
        total++;
        if (got_q.size() != 8) begin
            bad++; $display("FAIL stream_count: got %0d want 8", got_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                total++;
                if (got_q[i].d !== DW'(i + 1)) begin
                    bad++; $display("FAIL stream_order: got %0d want %0d",
                                    got_q[i].d, i + 1);
                end
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_stall();
        logic [DW-1:0] held;
        int            acc;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_rand();
            held = in_data;
            tick();
        end
        out_ready = 1'b0;
        drive_rand();
        acc = 0;
        for (int k = 0; k < 3; k++) begin
            if (m_in_fire) drive_rand();
            tick();
            if (dut_in_fire) acc++;
            total++;
            if (out_data !== held || !out_valid) begin
                bad++; $display("FAIL stall_hold: got v=%b d=%h want d=%h",
                                out_valid, out_data, held);
            end
        end
        total++;
        if (acc != 1) begin
            bad++; $display("FAIL stall_accepts: got %0d want 1", acc);
        end
        total++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
            bad++; $display("FAIL stall_full: got occ=%0d rdy=%b want 2/0",
                            occupancy, in_ready);
        end
        total++;
        if (stall_cnt !== 16'd3) begin
            bad++; $display("FAIL stall_cnt: got %0d want 3", stall_cnt);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (m_in_fire) drive_rand();
            tick();
            total++;
            if (!out_valid) begin
                bad++; $display("FAIL stall_gap: got out_valid=0 want 1");
            end
        end
        in_valid = 1'b0;
        repeat (3) tick();
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++; $display("FAIL stall_count: got %0d want %0d",
                            got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                total++;
                if (got_q[i] !== exp_q[i]) begin
                    bad++; $display("FAIL stall_seq: got %h want %h",
                                    got_q[i], exp_q[i]);
                end
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_flush();
        idle();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 4'b1001;
        for (int i = 5; i <= 6; i++) begin
            in_data = DW'(i);
            in_rd   = RW'(i);
            tick();
        end
        total++;
        if (occupancy !== 2'd2) begin
            bad++; $display("FAIL flush_pre: got occ=%0d want 2", occupancy);
        end
        in_data = 64'd7;
        in_rd   = 5'd7;
        flush   = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0 || out_ctrl !== '0 || fwd_we !== 1'b0) begin
            bad++; $display("FAIL flush_out: got v=%b c=%b fwd=%b want 0",
                            out_valid, out_ctrl, fwd_we);
        end
        total++;
        if (occupancy !== 2'd0 || in_ready !== 1'b1 || out_rd !== '0) begin
            bad++; $display("FAIL flush_state: got occ=%0d rdy=%b rd=%0d want 0/1/0",
                            occupancy, in_ready, out_rd);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (out_valid !== 1'b0) begin
                bad++; $display("FAIL flush_ghost: got out_valid=%b d=%0d want 0",
                                out_valid, out_data);
            end
        end
        in_valid = 1'b1;
        in_data  = 64'd8;
        in_rd    = 5'd8;
        tick();
        in_data = 64'd9;
        in_rd   = 5'd9;
        flush   = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL flush_drop: got out_valid=%b d=%0d want 0",
                            out_valid, out_data);
        end
        total++;
        if (got_q.size() != 1 || exp_q.size() != 1) begin
            bad++; $display("FAIL flush_deliver: got %0d beats want 1", got_q.size());
        end else begin
            total++;
            if (got_q[0] !== exp_q[0] || got_q[0].d !== 64'd8) begin
                bad++; $display("FAIL flush_beat: got %h want %h", got_q[0], exp_q[0]);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        beat_t sent[$];
        idle();
        in_valid = 1'b1;
        for (int k = 0; k < 11; k++) begin
            drive_rand();
            sent.push_back({in_ctrl, in_data, in_rd});
            tick();
            total++;
            if (occupancy !== 2'd1) begin
                bad++; $display("FAIL b2b_occ: got %0d want 1", occupancy);
            end
        end
        in_valid = 1'b0;
        tick();
        total++;
        if (got_q.size() != sent.size()) begin
            bad++; $display("FAIL b2b_count: got %0d want %0d",
                            got_q.size(), sent.size());
        end else begin
            foreach (sent[i]) begin
                total++;
                if (got_q[i] !== sent[i]) begin
                    bad++; $display("FAIL b2b_seq: got %h want %h",
                                    got_q[i], sent[i]);
                end
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_full();
        logic [DW-1:0] y;
        idle();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive_rand();
        tick();
        drive_rand();
        tick();
        tick();
        rst       = 1'b1;
        out_ready = 1'b1;
        flush     = 1'b1;
        tick();
        rst   = 1'b0;
        flush = 1'b0;
        total++;
        if ({out_valid, out_ctrl, out_data, out_rd, fwd_we, occupancy} !== '0) begin
            bad++; $display("FAIL rstfull_out: v=%b c=%b d=%h rd=%0d occ=%0d want 0",
                            out_valid, out_ctrl, out_data, out_rd, occupancy);
        end
        total++;
        if (in_ready !== 1'b1 || stall_cnt !== '0 || stall_cnt2 !== '0) begin
            bad++; $display("FAIL rstfull_misc: rdy=%b st=%0d st2=%0d want 1/0/0",
                            in_ready, stall_cnt, stall_cnt2);
        end
        out_ready = 1'b0;
        drive_rand();
        in_ctrl = 4'b0001;
        y = in_data;
        tick();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_data !== y || fwd_we !== 1'b1) begin
            bad++; $display("FAIL rstfull_first: got v=%b d=%h want 1/%h",
                            out_valid, out_data, y);
        end
    endtask

    task automatic test_saturate();
        for (int k = 1; k <= 6; k++) begin
            tick();
            total++;
            if (stall_cnt !== 16'(k)) begin
                bad++; $display("FAIL sat_wide: got %0d want %0d", stall_cnt, k);
            end
            total++;
            if (stall_cnt2 !== 2'((k > 3) ? 3 : k)) begin
                bad++; $display("FAIL sat_narrow: got %0d want %0d",
                                stall_cnt2, (k > 3) ? 3 : k);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_random();
        beat_t h;
        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            drive_rand();
            tick();
            total++;
            if (out_valid !== (mq.size() > 0) || occupancy !== 2'(mq.size())
                || in_ready !== (mq.size() < 2)) begin
                bad++; $display("FAIL rnd_state: v=%b occ=%0d rdy=%b want occ=%0d",
                                out_valid, occupancy, in_ready, mq.size());
            end
            if (mq.size() > 0) begin
                h = mq[0];
                total++;
                if ({out_ctrl, out_data, out_rd} !== h || fwd_we !== h.c[0]) begin
                    bad++; $display("FAIL rnd_head: got %h fwd=%b want %h",
                                    {out_ctrl, out_data, out_rd}, fwd_we, h);
                end
            end else begin
                total++;
                if (out_ctrl !== '0 || fwd_we !== 1'b0) begin
                    bad++; $display("FAIL rnd_bubble: got c=%b fwd=%b want 0",
                                    out_ctrl, fwd_we);
                end
            end
            total++;
            if (stall_cnt !== 16'(m_stall) || stall_cnt2 !== 2'(m_stall2)) begin
                bad++; $display("FAIL rnd_stall: got %0d/%0d want %0d/%0d",
                                stall_cnt, stall_cnt2, m_stall, m_stall2);
            end
        end
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++; $display("FAIL rnd_count: got %0d want %0d",
                            got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                total++;
                if (got_q[i] !== exp_q[i]) begin
                    bad++; $display("FAIL rnd_seq: got %h want %h",
                                    got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        m_stall = 0;
        m_stall2 = 0;
        m_in_fire = 1'b0;
        dut_in_fire = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_back_to_back();
        test_reset_full();
        test_saturate();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline stage register that replaces the fixed-field, always-advancing stage registers between Execute, Memory and Writeback. Carries a control vector, a data vector and a destination register index through a 2-entry skid buffer with valid/ready handshake, synchronous flush and a registered `in_ready`. `in_ready` has no combinational path from `out_ready`, so back-pressure never creates a long timing arc across stages. Instantiated once per stage boundary, with `CTRL_W`/`DATA_W` sized to that boundary.

## Interface
- `CTRL_W`, 4, control bits per beat (RegWrite, MemRead, MemWrite, MemToReg for EX/MEM)
- `DATA_W`, 64, data bits per beat (e.g. ALU result concatenated with store data)
- `RD_W`, 5, destination register index width
- `RW_BIT`, 0, index of the RegWrite bit inside the control vector
- `CNT_W`, 16, width of the stall cycle counter
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  upstream beat present
- `in_ready`  out  1  stage can accept; registered
- `in_ctrl`  in  CTRL_W  control vector
- `in_data`  in  DATA_W  data vector
- `in_rd`  in  RD_W  destination register
- `flush`  in  1  discard all held beats and any beat accepted this cycle
- `out_valid`  out  1  head beat present
- `out_ready`  in  1  downstream accepts head beat
- `out_ctrl`  out  CTRL_W  head control, forced 0 when `out_valid`=0
- `out_data`  out  DATA_W  head data
- `out_rd`  out  RD_W  head destination register
- `fwd_we`  out  1  `out_valid & out_ctrl[RW_BIT]`, for the forwarding unit
- `occupancy`  out  2  beats held (0..2)
- `stall_cnt`  out  CNT_W  saturating count of cycles with `out_valid & !out_ready`

## Operation
- Storage: head entry (drives outputs) and skid entry, each holding valid, ctrl, data and rd.
- `in_fire = in_valid & in_ready`; `out_fire = out_valid & out_ready`.
- States by occupancy:
  - EMPTY (0): on `in_fire`, head <= input; go to ONE.
  - ONE (1): `in_fire & out_fire` -> head <= input, stay in ONE. `in_fire & !out_fire` -> skid <= input, go to FULL. `!in_fire & out_fire` -> go to EMPTY. Otherwise hold.
  - FULL (2): `in_ready`=0. `out_fire` -> head <= skid, skid invalid, go to ONE. Otherwise hold.
- `in_ready` is registered and equals NOT(next skid valid): 1 in EMPTY and ONE, 0 in FULL.
- `flush` has priority over all transitions. Next state is EMPTY, both valids are cleared, and both ctrl and rd fields are cleared to 0. A beat accepted in the flush cycle is dropped. A head beat taken by downstream in the flush cycle counts as delivered. Data fields hold their values.
- `out_ctrl` = head ctrl AND'ed with head valid, so a bubble never asserts RegWrite, MemRead or MemWrite.
- `stall_cnt` increments when `out_valid & !out_ready`, saturates at all-ones, and is unaffected by `flush`.
- Beat order is strictly FIFO. No beat is duplicated or lost except by `flush`.

## Timing
- Reset (`rst` high at a rising edge):
  - `out_valid`=0, `in_ready`=1, `out_ctrl`=0, `out_data`=0, `out_rd`=0.
  - `fwd_we`=0, `occupancy`=0, `stall_cnt`=0; skid entry cleared.
  - Reset overrides `flush` and handshakes in the same cycle.
- Latency: a beat accepted at edge N is visible on `out_*` after edge N (1 cycle) when the stage was EMPTY, or when it was ONE with `out_fire`.
- Throughput: 1 beat/cycle sustained while `out_ready`=1.
- After `out_ready` drops, at most one more beat is accepted (into skid) before `in_ready` falls on the next edge.
- `in_ready` rises the cycle after the FULL->ONE transition.
- Inputs are sampled only on `in_fire`. `out_*` is stable while `out_valid & !out_ready`.

## Test plan
- Reset, then stream ctrl=4'b1001, data=1..8, rd=1..8 with `out_ready`=1:
  - beats emerge 1 cycle later, in order;
  - `occupancy` stays 1; `fwd_we`=1 on each.
- With a stream in flight, hold `out_ready`=0 for 3 cycles:
  - exactly one extra beat is accepted; `occupancy`=2; `in_ready`=0;
  - `stall_cnt`=3; `out_data` holds; on release, data continues with no gap, loss or repeat.
- FULL with heads 5 and 6, assert `flush` together with `in_valid` carrying data 7:
  - next cycle `out_valid`=0, `out_ctrl`=0, `occupancy`=0, `in_ready`=1;
  - 7 never appears at the output.
- In ONE, assert `in_fire` and `out_fire` in the same cycle for 10 cycles:
  - occupancy stays 1; every beat emerges exactly once.
- Assert `rst` while FULL and mid-stall:
  - all outputs reach their reset values after one edge;
  - `stall_cnt`=0; the first beat after reset emerges 1 cycle after acceptance.
- With `CNT_W`=2, stall for 6 cycles:
  - `stall_cnt` saturates at 3.
